// File: rtl/dac_pkg.sv
// dac_pkg: shared state encoding, widths and timing defaults for the DAC arbiter
package dac_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;
  localparam int DAC_DATA_W = 10;
  // One 16-bit SPI frame at the spi2dac SCK rate plus margin, in 50 MHz cycles.
  localparam int XFER_CYCLES_50M = 1000;
  function automatic int cnt_w(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter that saturates at zero and flags it
module frame_timer #(
  parameter int W = 1
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge sysclk)
    if (!rst_n) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/dac_arbiter.sv
// dac_arbiter: two-producer arbiter for the shared spi2dac load path.
// Define DAC_ARB_FIXED_PRIO_EN for strict producer-0 priority instead of round-robin.
module dac_arbiter
  import dac_pkg::*;
#(
  parameter int XFER_CYCLES = XFER_CYCLES_50M,
  parameter int DATA_W      = DAC_DATA_W
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_load,
  output logic              busy,
  output logic              grant_id
);
  localparam int CW = cnt_w(XFER_CYCLES);
  state_t state, state_nx;
  logic   req_any, win, zero;
  assign req_any = req0 | req1;
`ifdef DAC_ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  assign win = (req0 & req1) ? ~grant_id : req1;
`endif
  always_comb begin
    dac_load = state == LOAD;
    ack0     = dac_load & ~grant_id;
    ack1     = dac_load & grant_id;
    busy     = state != IDLE;
    state_nx = state == IDLE ? (req_any ? LOAD : IDLE) :
               state == LOAD ? BUSY : (zero ? IDLE : BUSY);
  end
  always_ff @(posedge sysclk)
    if (!rst_n) begin
      state    <= IDLE;
      dac_data <= '0;
      grant_id <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_any) begin
        dac_data <= win ? data1 : data0;
        grant_id <= win;
      end
    end
  // LOAD accounts for the first window cycle, so the timer covers the rest.
  frame_timer #(.W(CW)) u_timer (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .load     (dac_load),
    .en       (state == BUSY),
    .load_val (CW'(XFER_CYCLES - 2)),
    .zero     (zero)
  );
endmodule

// File: doc/dac_arbiter.md
# dac_arbiter

Shares the single SPI DAC path (the `spi2dac` serialiser and its `load` strobe) between two independent sample producers, such as a tick-paced test source and a waveform generator. Each producer raises a request with a 10-bit sample. The arbiter picks one, presents its sample on the serialiser's data input and issues a one-cycle load strobe. It then blocks further loads until the SPI frame has completed. The block sits between the requesters and `spi2dac` in the DAC top level, replacing the free-running tick that drove `load` directly.

## Interface
Parameters:
- `XFER_CYCLES`, default 1000: sysclk cycles reserved per DAC frame, counted from the load strobe; legal range 2..65535.
- `DATA_W`, default 10: sample width, which matches the `spi2dac` data input.

Ports:
- `sysclk` in, 1: single clock, 50 MHz.
- `rst_n` in, 1: synchronous, active-low reset.
- `req0`, `req1` in, 1 each: request from producer 0 or 1; held high until its ack is seen.
- `data0`, `data1` in, `DATA_W` each: sample from the producer; must be stable while its req is high.
- `ack0`, `ack1` out, 1 each: one-cycle pulse when the producer's sample is launched.
- `dac_data` out, `DATA_W`: sample to the `spi2dac` data input; registered.
- `dac_load` out, 1: one-cycle strobe to the `spi2dac` load input.
- `busy` out, 1: high from the load strobe until the reserved window ends.
- `grant_id` out, 1: index of the producer most recently granted.

## Operation
- State machine: IDLE, LOAD, BUSY.
- IDLE, no req: stay in IDLE.
- IDLE, one or more req: choose a winner, latch its data into `dac_data`, set `grant_id`, go to LOAD.
- LOAD (exactly one cycle): `dac_load`=1, the winner's ack=1, `busy`=1; load counter with `XFER_CYCLES-2`; go to BUSY.
- BUSY: `busy`=1; decrement counter; when counter=0, go to IDLE.
- Round-robin rule for simultaneous req0 and req1: grant the index opposite `grant_id`.
- Round-robin rule for a single requester: it wins regardless of `grant_id`.
- Requests raised during LOAD or BUSY wait; no request is dropped or queued beyond the held req.
- If a req drops before its ack, it is simply not considered; the sample already latched is still sent.
- `dac_data` holds its last value outside LOAD/BUSY; it is not cleared on idle.
- Counter width is `$clog2(XFER_CYCLES)`, minimum 1. The counter never wraps: it stops at 0.

## Timing
- Reset values: state=IDLE, `dac_data`=0, `dac_load`=0, `ack0`=`ack1`=0, `busy`=0, `grant_id`=1 (so producer 0 wins the first tie), counter=0.
- Reset applied mid-frame aborts the window immediately on the next edge. `spi2dac` may finish its frame on its own; that is harmless.
- Latency: req sampled high in IDLE at edge N gives `dac_load` and ack high during cycle N+1.
- Window: the load-to-load interval is at least `XFER_CYCLES`+1 cycles; back-to-back requests achieve exactly that.
- `busy` rises with `dac_load` and falls on the cycle the state returns to IDLE. Total `busy` high time is `XFER_CYCLES` cycles.
- Ack and `dac_load` are always coincident; never more than one ack per cycle.

## Configuration
- `DAC_ARB_FIXED_PRIO_EN`, defined: producer 0 always wins ties (strict priority). `grant_id` is still updated but is unused for arbitration.
- `DAC_ARB_FIXED_PRIO_EN`, undefined (default): round-robin as described under Operation.

## Structure
- Shared package `dac_pkg` holds:
  - the state enum (IDLE/LOAD/BUSY);
  - `DAC_DATA_W`=10;
  - the default `XFER_CYCLES_50M`=1000, which leaves margin over one 16-bit SPI frame at the `spi2dac` SCK rate.
- One natural sub-module, `frame_timer`: a loadable down-counter with a zero flag that implements the BUSY window.
- Arbitration and FSM stay in `dac_arbiter`.

## Test plan
- Reset, then `req0`=1, `data0`=0x2A5 → one cycle later `dac_load`=1, `ack0`=1, `dac_data`=0x2A5, `grant_id`=0. `busy` is high for exactly 1000 cycles.
- Simultaneous `req0`=`req1`=1, held → grants alternate 0,1,0,1; each load is 1001 cycles apart; data matches the granted producer.
- `req1` raised during BUSY of a producer-0 frame → `ack1` only after `busy` falls, plus one cycle; no extra load occurs.
- `rst_n`=0 for one cycle mid-BUSY → all outputs at reset values next cycle. A pending `req0` gets granted on the second cycle after release.
- With `DAC_ARB_FIXED_PRIO_EN` defined and both reqs held → `ack0` every frame, `ack1` never while `req0` stays high.
- `XFER_CYCLES`=2 → load strobes exactly 3 cycles apart under continuous requests.
